// File: rtl/timer_counter_pkg.sv
// Shared constants for the timer counter: state encodings, mode/direction codes, default width.
package timer_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/timer_counter_edge_detect_rise.sv
// Samples a pclk-synchronous level and emits a one-cycle pulse on each rising edge.
module edge_detect_rise (
  input  logic pclk,
  input  logic preset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // Previous-cycle copy of the input level.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/timer_counter.sv
// Up/down counter driven by rising edges of int_clk, with load, wrap flags and one-shot mode.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             int_clk,
  input  logic             en,
  input  logic             mode,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] tdr,
  input  logic             clr_ovf,
  input  logic             clr_udf,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf,
  output logic             udf,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic   tick;
  logic   cnt_step;
  logic   wrap_up;
  logic   wrap_dn;
  state_t state;
  state_t state_next;

  edge_detect_rise u_tick (
    .pclk   (pclk),
    .preset (preset),
    .d      (int_clk),
    .pulse  (tick)
  );

  // A tick only advances the count while running and enabled; a load in the same cycle drops it.
  assign cnt_step = (state == RUN) && en && tick && !load;
  assign wrap_up  = cnt_step && (up_down == DIR_UP)   && (cnt == MAX);
  assign wrap_dn  = cnt_step && (up_down == DIR_DOWN) && (cnt == '0);

  // Next-state logic: enable gates RUN, a one-shot wrap parks in DONE until en drops.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en) state_next = RUN;
      RUN: begin
        if (!en)                                             state_next = IDLE;
        else if ((mode == MODE_ONESHOT) && (wrap_up || wrap_dn)) state_next = DONE;
      end
      DONE:    if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; busy is registered alongside so it always equals (state == RUN).
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
    end
  end

  // Counter: load has priority over counting; arithmetic wraps modulo 2**WIDTH.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset)        cnt <= '0;
    else if (load)     cnt <= tdr;
    else if (cnt_step) cnt <= (up_down == DIR_UP) ? cnt + 1'b1 : cnt - 1'b1;
  end

  // Sticky wrap flags; a set in the same cycle as a clear keeps the flag high.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wrap_up)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      if (wrap_dn)      udf <= 1'b1;
      else if (clr_udf) udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: expectations queued before stimulus, popped and checked after.
module tb_timer_counter;

  logic       pclk;
  logic       preset;
  logic       int_clk;
  logic       en;
  logic       mode;
  logic       up_down;
  logic       load;
  logic [7:0] tdr;
  logic       clr_ovf;
  logic       clr_udf;
  logic [7:0] cnt;
  logic       ovf;
  logic       udf;
  logic       busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [10:0] val;   // {cnt, ovf, udf, busy}
  } exp_t;

  exp_t sb[$];

  timer_counter #(.WIDTH(8)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .int_clk (int_clk),
    .en      (en),
    .mode    (mode),
    .up_down (up_down),
    .load    (load),
    .tdr     (tdr),
    .clr_ovf (clr_ovf),
    .clr_udf (clr_udf),
    .cnt     (cnt),
    .ovf     (ovf),
    .udf     (udf),
    .busy    (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge pclk);
  endtask

  // One int_clk period of two pclk cycles: exactly one tick.
  task automatic tk();
    int_clk = 1'b1;
    step();
    int_clk = 1'b0;
    step();
  endtask

  task automatic push(input string tag, input logic [7:0] c, input logic o, input logic u,
                      input logic b);
    exp_t e;
    e.tag = tag;
    e.val = {c, o, u, b};
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t        e;
    logic [10:0] obs;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard: observed no queued expectation, required one");
      return;
    end
    e   = sb.pop_front();
    obs = {cnt, ovf, udf, busy};
    assert (obs === e.val) else begin
      fails++;
      $error("FAIL %s: observed cnt=%02h ovf=%0b udf=%0b busy=%0b, expected cnt=%02h ovf=%0b udf=%0b busy=%0b",
             e.tag, obs[10:3], obs[2], obs[1], obs[0], e.val[10:3], e.val[2], e.val[1], e.val[0]);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    tdr  = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    preset  = 1'b1;
    int_clk = 1'b0;
    en      = 1'b0;
    mode    = 1'b0;
    up_down = 1'b0;
    load    = 1'b0;
    tdr     = '0;
    clr_ovf = 1'b0;
    clr_udf = 1'b0;

    // Test 1: reset state, asynchronous reset mid-count
    push("reset", 8'h00, 0, 0, 0);
    step(); step();
    chk();
    preset = 1'b0;
    do_load(8'h36);
    en = 1'b1;
    step();
    push("t1_count37", 8'h37, 0, 0, 1);
    tk();
    chk();
    push("t1_async_reset", 8'h00, 0, 0, 0);
    #2 preset = 1'b1;
    #1 chk();
    step();
    en     = 1'b0;
    preset = 1'b0;
    push("t1_idle_after_release", 8'h00, 0, 0, 0);
    step();
    chk();
    push("t1_idle_no_count", 8'h00, 0, 0, 0);
    tk();
    chk();

    // Test 2: up count through MAX, overflow, clear
    up_down = 1'b0;
    push("t2_load_fd", 8'hFD, 0, 0, 0);
    do_load(8'hFD);
    chk();
    en = 1'b1;
    push("t2_run", 8'hFD, 0, 0, 1);
    step();
    chk();
    push("t2_fe", 8'hFE, 0, 0, 1); tk(); chk();
    push("t2_ff", 8'hFF, 0, 0, 1); tk(); chk();
    push("t2_wrap00", 8'h00, 1, 0, 1); tk(); chk();
    push("t2_ovf_held", 8'h01, 1, 0, 1); tk(); chk();
    push("t2_clr_ovf", 8'h01, 0, 0, 1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk();

    // Test 3: down count through zero, underflow
    en = 1'b0; step();
    up_down = 1'b1;
    push("t3_load_01", 8'h01, 0, 0, 0);
    do_load(8'h01);
    chk();
    en = 1'b1;
    push("t3_run", 8'h01, 0, 0, 1); step(); chk();
    push("t3_00", 8'h00, 0, 0, 1); tk(); chk();
    push("t3_wrapff", 8'hFF, 0, 1, 1); tk(); chk();
    push("t3_clr_udf", 8'hFF, 0, 0, 1);
    clr_udf = 1'b1; step(); clr_udf = 1'b0;
    chk();

    // Test 4: one-shot mode stops at wrap, restarts through IDLE
    en = 1'b0; step();
    mode    = 1'b1;
    up_down = 1'b0;
    do_load(8'hFE);
    en = 1'b1;
    push("t4_run_fe", 8'hFE, 0, 0, 1); step(); chk();
    push("t4_ff", 8'hFF, 0, 0, 1); tk(); chk();
    push("t4_done00", 8'h00, 1, 0, 0); tk(); chk();
    push("t4_done_hold", 8'h00, 1, 0, 0); tk(); tk(); tk(); chk();
    en = 1'b0; step();
    en = 1'b1;
    push("t4_rerun", 8'h00, 1, 0, 1); step(); chk();
    push("t4_01", 8'h01, 1, 0, 1); tk(); chk();
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    mode = 1'b0;

    // Test 5: load on the same cycle as a tick wins
    en = 1'b0; step();
    do_load(8'h10);
    en = 1'b1;
    push("t5_run_10", 8'h10, 0, 0, 1); step(); chk();
    push("t5_load_wins", 8'h80, 0, 0, 1);
    tdr = 8'h80; load = 1'b1; int_clk = 1'b1;
    step();
    load = 1'b0; int_clk = 1'b0;
    step();
    chk();
    push("t5_81", 8'h81, 0, 0, 1); tk(); chk();

    // Test 6: overflow set beats clear; en=0 mid-run holds count
    en = 1'b0; step();
    do_load(8'hFF);
    en = 1'b1; step();
    push("t6_set_beats_clr", 8'h00, 1, 0, 1);
    clr_ovf = 1'b1; int_clk = 1'b1;
    step();
    clr_ovf = 1'b0; int_clk = 1'b0;
    step();
    chk();
    push("t6_clr_ovf", 8'h00, 0, 0, 1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk();
    push("t6_count05", 8'h05, 0, 0, 1);
    for (int unsigned i = 0; i < 5; i++) tk();
    chk();
    push("t6_en_off", 8'h05, 0, 0, 0);
    en = 1'b0; step();
    chk();
    push("t6_hold05", 8'h05, 0, 0, 0); tk(); chk();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
